// File: rtl/ota_cal_pkg.sv
// Shared types and helpers for the OTA offset-trim controller.
// Holds the controller state encoding and parameter legality limits.
package ota_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SAR_WAIT   = 3'd1,
        ST_SAR_DECIDE = 3'd2,
        ST_TRK_WAIT   = 3'd3,
        ST_TRK_DECIDE = 3'd4
    } ota_cal_state_e;

    localparam int NCH_MIN    = 1;
    localparam int TRIM_W_MIN = 2;
    localparam int SETTLE_MIN = 1;
    localparam int TRK_N_MIN  = 1;

    function automatic int midscale(input int width);
        return 1 << (width - 1);
    endfunction

    function automatic bit params_ok(input int nch, input int trim_w,
                                     input int settle, input int trk_n);
        return (nch >= NCH_MIN) && (trim_w >= TRIM_W_MIN) &&
               (settle >= SETTLE_MIN) && (trk_n >= TRK_N_MIN);
    endfunction

endpackage

// File: rtl/ota_trim_ctrl_if.sv
// Bundle between the trim controller and the OTA array (comparators and trim DACs).
// master = controller side, slave = OTA array / environment side.
interface ota_trim_ctrl_if #(
    parameter int NCH    = 4,
    parameter int TRIM_W = 6
);
    import ota_cal_pkg::*;

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    // start is a one-cycle request taken only while busy is low; done is a one-cycle
    // pulse when every channel's search has finished; cmp_i is sampled only on decide cycles.
    logic                    start;
    logic                    track_en;
    logic [NCH-1:0]          cmp_i;
    logic                    cal_en;
    logic [CH_W-1:0]         ch_sel;
    logic [NCH*TRIM_W-1:0]   trim_code;
    logic                    busy;
    logic                    done;
    logic [NCH-1:0]          sat;
    ota_cal_state_e          dbg_state;

    modport master (
        input  start, track_en, cmp_i,
        output cal_en, ch_sel, trim_code, busy, done, sat, dbg_state
    );

    modport slave (
        output start, track_en, cmp_i,
        input  cal_en, ch_sel, trim_code, busy, done, sat, dbg_state
    );

endinterface

// File: rtl/ota_cal_timer.sv
// Settling down-counter: load restarts a SETTLE-cycle wait, expired marks the
// cycle on which the settled comparator may be trusted.
module ota_cal_timer #(
    parameter int SETTLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic expired_o
);
    localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = TW'(SETTLE - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ota_trim_ctrl.sv
// Offset-trim controller for NCH OTAs: per-channel SAR search of the trim code,
// followed by optional round-robin +/-1 LSB background tracking.
module ota_trim_ctrl
    import ota_cal_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int TRIM_W = 6,
    parameter int SETTLE = 16,
    parameter int TRK_N  = 4
) (
    input logic             clk,
    input logic             rst,
    ota_trim_ctrl_if.master bus
);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BIT_W = $clog2(TRIM_W);
    localparam int RUN_W = $clog2(TRK_N + 1) + 1;

    typedef logic [TRIM_W-1:0]       code_t;
    typedef logic signed [RUN_W-1:0] run_t;

    localparam code_t            MID      = code_t'(midscale(TRIM_W));
    localparam code_t            CODE_MAX = {TRIM_W{1'b1}};
    localparam run_t             RUN_HI   = run_t'(TRK_N);
    localparam run_t             RUN_LO   = run_t'(-TRK_N);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NCH - 1);
    localparam logic [BIT_W-1:0] TOP_BIT  = BIT_W'(TRIM_W - 1);

    if (!params_ok(NCH, TRIM_W, SETTLE, TRK_N)) begin : g_bad_params
        $error("ota_trim_ctrl: illegal parameter set");
    end

    ota_cal_state_e   state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    code_t            code_q [NCH];
    code_t            code_d [NCH];
    run_t             run_q  [NCH];
    run_t             run_d  [NCH];
    logic [NCH-1:0]   sat_q, sat_d;
    logic             busy_q, busy_d;
    logic             cal_en_q, cal_en_d;
    logic             done_q, done_d;

    logic  in_sar, start_acc, cmp_sel, last_bit, last_ch;
    logic  tmr_load, tmr_expired;
    code_t cur_code, sar_code;
    run_t  step_run;

    assign in_sar    = (state_q == ST_SAR_WAIT) || (state_q == ST_SAR_DECIDE);
    assign start_acc = bus.start && !in_sar;
    assign cmp_sel   = bus.cmp_i[ch_q];
    assign cur_code  = code_q[ch_q];
    assign last_bit  = (bit_q == '0);
    assign last_ch   = (ch_q == LAST_CH);

    // Restart the settle wait whenever a wait state is freshly entered.
    assign tmr_load = (state_d != state_q) &&
                      ((state_d == ST_SAR_WAIT) || (state_d == ST_TRK_WAIT));

    ota_cal_timer #(.SETTLE(SETTLE)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            bit_q    <= TOP_BIT;
            for (int c = 0; c < NCH; c++) begin
                code_q[c] <= MID;
                run_q[c]  <= '0;
            end
            sat_q    <= '0;
            busy_q   <= 1'b0;
            cal_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            bit_q    <= bit_d;
            code_q   <= code_d;
            run_q    <= run_d;
            sat_q    <= sat_d;
            busy_q   <= busy_d;
            cal_en_q <= cal_en_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_acc) begin
            state_d = ST_SAR_WAIT;
        end else begin
            case (state_q)
                ST_IDLE:       state_d = ST_IDLE;
                ST_SAR_WAIT:   if (tmr_expired) state_d = ST_SAR_DECIDE;
                ST_SAR_DECIDE: begin
                    if (last_bit && last_ch) begin
                        state_d = bus.track_en ? ST_TRK_WAIT : ST_IDLE;
                    end else begin
                        state_d = ST_SAR_WAIT;
                    end
                end
                ST_TRK_WAIT:   if (tmr_expired) state_d = ST_TRK_DECIDE;
                ST_TRK_DECIDE: state_d = bus.track_en ? ST_TRK_WAIT : ST_IDLE;
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ch_d     = ch_q;
        bit_d    = bit_q;
        code_d   = code_q;
        run_d    = run_q;
        sat_d    = sat_q;
        busy_d   = busy_q;
        cal_en_d = cal_en_q;
        done_d   = 1'b0;
        sar_code = cur_code;
        step_run = '0;

        if (start_acc) begin
            ch_d     = '0;
            bit_d    = TOP_BIT;
            for (int c = 0; c < NCH; c++) begin
                code_d[c] = MID;
                run_d[c]  = '0;
            end
            sat_d    = '0;
            busy_d   = 1'b1;
            cal_en_d = 1'b1;
        end else begin
            case (state_q)
                ST_SAR_DECIDE: begin
                    if (!cmp_sel) sar_code[bit_q] = 1'b0;
                    if (!last_bit) begin
                        sar_code[bit_q - 1'b1] = 1'b1;
                        bit_d                  = bit_q - 1'b1;
                        code_d[ch_q]           = sar_code;
                    end else begin
                        code_d[ch_q] = sar_code;
                        sat_d[ch_q]  = (cmp_sel && (sar_code == CODE_MAX)) ||
                                       (!cmp_sel && (sar_code == '0));
                        if (!last_ch) begin
                            ch_d                 = ch_q + 1'b1;
                            bit_d                = TOP_BIT;
                            code_d[ch_q + 1'b1]  = MID;
                        end else begin
                            done_d   = 1'b1;
                            busy_d   = 1'b0;
                            cal_en_d = 1'b0;
                            ch_d     = '0;
                        end
                    end
                end
                ST_TRK_DECIDE: begin
                    if (bus.track_en) begin
                        // Signed run length: a change of direction restarts at +/-1.
                        if (cmp_sel) begin
                            step_run = (run_q[ch_q] > run_t'(0)) ? run_q[ch_q] + run_t'(1) : run_t'(1);
                        end else begin
                            step_run = (run_q[ch_q] < run_t'(0)) ? run_q[ch_q] - run_t'(1) : run_t'(-1);
                        end
                        run_d[ch_q] = step_run;
                        if (step_run == RUN_HI) begin
                            run_d[ch_q] = '0;
                            if (cur_code == CODE_MAX) begin
                                sat_d[ch_q] = 1'b1;
                            end else begin
                                code_d[ch_q] = cur_code + 1'b1;
                                sat_d[ch_q]  = 1'b0;
                            end
                        end else if (step_run == RUN_LO) begin
                            run_d[ch_q] = '0;
                            if (cur_code == '0) begin
                                sat_d[ch_q] = 1'b1;
                            end else begin
                                code_d[ch_q] = cur_code - 1'b1;
                                sat_d[ch_q]  = 1'b0;
                            end
                        end
                        ch_d = last_ch ? '0 : ch_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_pack
        assign bus.trim_code[c*TRIM_W +: TRIM_W] = code_q[c];
    end

    assign bus.ch_sel    = ch_q;
    assign bus.busy      = busy_q;
    assign bus.cal_en    = cal_en_q;
    assign bus.done      = done_q;
    assign bus.sat       = sat_q;
    assign bus.dbg_state = state_q;

endmodule
